memory_arbiter: RTL and testbench

- Shares the single-port 8-bit memory (one read address, one write port) between two requesters (m0, m1) using round-robin arbitration and a req/ack handshake.
- Registers read data back to the winning requester.
- Provides a clear sequencer that walks the whole memory writing 8'h00, so software can zero memory without a reset.
- Sits between the CPU-side masters (e.g. fetch and load/store) and the memory instance.

---
 rtl/memory_arbiter.sv | 88 ++++++++
 tb/tb_memory_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin req/ack arbiter sharing one memory between two requesters, with a clear sweep
//   clock_i          system clock, rising edge
//   reset_ni         asynchronous active-low reset
//   mX_req_i/mX_write_i/mX_address_i/mX_write_data_i   requester X access (held until mX_ack_o)
//   mX_ack_o         combinational grant, access happens at this edge
//   mX_read_valid_o/mX_read_data_o   registered read result, valid one cycle after a read ack
//   clear_start_i/clear_busy_o       start / progress of the zeroing sweep
//   mem_*            drive to and combinational read data from the memory instance
module memory_arbiter #(
  parameter int CELL_COUNT = 256
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       m0_req_i,
  input  logic       m0_write_i,
  input  logic [7:0] m0_address_i,
  input  logic [7:0] m0_write_data_i,
  output logic       m0_ack_o,
  output logic       m0_read_valid_o,
  output logic [7:0] m0_read_data_o,
  input  logic       m1_req_i,
  input  logic       m1_write_i,
  input  logic [7:0] m1_address_i,
  input  logic [7:0] m1_write_data_i,
  output logic       m1_ack_o,
  output logic       m1_read_valid_o,
  output logic [7:0] m1_read_data_o,
  input  logic       clear_start_i,
  output logic       clear_busy_o,
  output logic [7:0] mem_read_address_o,
  output logic [7:0] mem_write_address_o,
  output logic [7:0] mem_write_data_o,
  output logic       mem_write_enable_o,
  input  logic [7:0] mem_read_data_i
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rv0_q, rv0_d, rv1_q, rv1_d;
  logic [7:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic       clr, done, g0, g1;
  assign clr  = state_q == CLEAR;
  assign done = cnt_q == 8'(CELL_COUNT - 1);
  // last_q names the previous winner (1 = m1), so on contention the other side wins;
  // reset_ni gates grants so an asserted reset suppresses side effects without waiting for an edge
  assign g0 = reset_ni & ~clr & m0_req_i & (~m1_req_i | last_q);
  assign g1 = reset_ni & ~clr & m1_req_i & (~m0_req_i | ~last_q);
  assign m0_ack_o            = g0;
  assign m1_ack_o            = g1;
  assign clear_busy_o        = clr;
  assign mem_write_enable_o  = reset_ni & (clr | (g0 & m0_write_i) | (g1 & m1_write_i));
  assign mem_write_address_o = clr ? cnt_q : g0 ? m0_address_i : g1 ? m1_address_i : 8'h00;
  assign mem_read_address_o  = mem_write_address_o;
  assign mem_write_data_o    = g0 ? m0_write_data_i : g1 ? m1_write_data_i : 8'h00;
  assign m0_read_valid_o     = rv0_q;
  assign m1_read_valid_o     = rv1_q;
  assign m0_read_data_o      = rd0_q;
  assign m1_read_data_o      = rd1_q;
  always_comb begin
    state_d = clr ? (done ? IDLE : CLEAR) : (clear_start_i ? CLEAR : IDLE);
    cnt_d   = (clr && !done) ? cnt_q + 8'd1 : 8'h00;
    last_d  = g0 ? 1'b0 : g1 ? 1'b1 : last_q;
    rv0_d   = g0 & ~m0_write_i;
    rv1_d   = g1 & ~m1_write_i;
    rd0_d   = rv0_d ? mem_read_data_i : rd0_q;
    rd1_d   = rv1_d ? mem_read_data_i : rd1_q;
  end
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'h00;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= 8'h00;
      rd1_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter against a high-level arbitration/memory model
module tb_memory_arbiter;
  localparam int CELLS = 256;
  typedef struct {int cyc; logic [7:0] d;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_req, m0_wr, m1_req, m1_wr, clr_start;
  logic [7:0] m0_a, m0_d, m1_a, m1_d;
  logic m0_ack, m1_ack, m0_rv, m1_rv, busy, we;
  logic [7:0] m0_rd, m1_rd, raddr, waddr, wdata, rdata;
  logic [7:0] mem [CELLS];
  logic [7:0] ref_mem [CELLS];
  logic [7:0] exp_rd0, exp_rd1;
  exp_t q0[$], q1[$];
  int checks = 0, errors = 0, cyc = 0, m_last = 1, m_cnt = 0, n;
  bit m_clr = 1'b0, g0, g1, p0, p1;

  memory_arbiter #(.CELL_COUNT(CELLS)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .m0_req_i(m0_req), .m0_write_i(m0_wr), .m0_address_i(m0_a), .m0_write_data_i(m0_d),
    .m0_ack_o(m0_ack), .m0_read_valid_o(m0_rv), .m0_read_data_o(m0_rd),
    .m1_req_i(m1_req), .m1_write_i(m1_wr), .m1_address_i(m1_a), .m1_write_data_i(m1_d),
    .m1_ack_o(m1_ack), .m1_read_valid_o(m1_rv), .m1_read_data_o(m1_rd),
    .clear_start_i(clr_start), .clear_busy_o(busy),
    .mem_read_address_o(raddr), .mem_write_address_o(waddr), .mem_write_data_o(wdata),
    .mem_write_enable_o(we), .mem_read_data_i(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    m_clr = 1'b0; m_cnt = 0; m_last = 1;
    q0.delete(); q1.delete();
    exp_rd0 = 8'h00; exp_rd1 = 8'h00;
  endtask

  task automatic req0(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
    m0_req = r; m0_wr = w; m0_a = a; m0_d = d;
  endtask

  task automatic req1(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
    m1_req = r; m1_wr = w; m1_a = a; m1_d = d;
  endtask

  // one clock cycle: predict combinational outputs, check them, then advance the model at the edge
  task automatic step(output bit o0, output bit o1);
    logic [7:0] a;
    logic [27:0] e;
    #4;
    o0 = 1'b0; o1 = 1'b0;
    if (!m_clr) begin
      if (m0_req && m1_req) begin o0 = (m_last == 1); o1 = !o0; end
      else begin o0 = m0_req; o1 = m1_req; end
    end
    a = m_clr ? 8'(m_cnt) : o0 ? m0_a : o1 ? m1_a : 8'h00;
    e = {o0, o1, m_clr, m_clr | (o0 & m0_wr) | (o1 & m1_wr), a, a, (o0 ? m0_d : o1 ? m1_d : 8'h00)};
    chk("comb", {m0_ack, m1_ack, busy, we, raddr, waddr, wdata}, 64'(e));
    @(posedge clk);
    cyc++;
    if (o0 && !m0_wr) q0.push_back('{cyc, ref_mem[m0_a]});
    if (o1 && !m1_wr) q1.push_back('{cyc, ref_mem[m1_a]});
    if (o0 && m0_wr) ref_mem[m0_a] = m0_d;
    if (o1 && m1_wr) ref_mem[m1_a] = m1_d;
    if (o0) m_last = 0;
    if (o1) m_last = 1;
    if (m_clr) begin
      ref_mem[m_cnt] = 8'h00;
      m_cnt++;
      if (m_cnt == CELLS) m_clr = 1'b0;
    end else if (clr_start) begin
      m_clr = 1'b1; m_cnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic s();
    bit a, b;
    step(a, b);
  endtask

  always @(negedge clk) if (rst_n) begin : mon
    bit e0, e1;
    e0 = q0.size() > 0 && q0[0].cyc == cyc;
    e1 = q1.size() > 0 && q1[0].cyc == cyc;
    chk("rv0", 64'(m0_rv), 64'(e0));
    chk("rv1", 64'(m1_rv), 64'(e1));
    if (e0) begin exp_rd0 = q0[0].d; void'(q0.pop_front()); end
    if (e1) begin exp_rd1 = q1[0].d; void'(q1.pop_front()); end
    chk("rd0", 64'(m0_rd), 64'(exp_rd0));
    chk("rd1", 64'(m1_rd), 64'(exp_rd1));
  end

  initial begin
    clr_start = 1'b0;
    req0(1, 0, 8'h00, 8'h00);
    req1(1, 0, 8'h00, 8'h00);
    for (int i = 0; i < CELLS; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[i] <= ref_mem[i];
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk("reset", 64'({m0_ack, m1_ack, we, busy, m0_rv, m1_rv, m0_rd, m1_rd}), 64'h0);
    @(negedge clk);
    req0(0, 0, 8'h00, 8'h00);
    req1(0, 0, 8'h00, 8'h00);
    rst_n = 1'b1;
    // write then read back
    req0(1, 1, 8'h10, 8'hA5); s();
    req0(1, 0, 8'h10, 8'h00); s();
    req0(0, 0, 8'h00, 8'h00); s(); s();
    // contention alternates
    req0(1, 0, 8'h10, 8'h00);
    req1(1, 0, 8'h20, 8'h00);
    repeat (4) s();
    // lone m1 back to back, then contention goes to m0
    req0(0, 0, 8'h00, 8'h00);
    repeat (3) s();
    req0(1, 0, 8'h11, 8'h00); s();
    req0(0, 0, 8'h00, 8'h00);
    req1(0, 0, 8'h00, 8'h00); s();
    // full clear with a restart attempt mid-sweep and a waiting requester
    req0(1, 1, 8'h00, 8'hFF); s();
    req0(1, 1, 8'h7F, 8'hFF); s();
    req0(1, 1, 8'hFF, 8'hFF); s();
    req0(0, 0, 8'h00, 8'h00);
    clr_start = 1'b1; s();
    clr_start = 1'b0;
    req0(1, 0, 8'h00, 8'h00);
    n = 0;
    while (busy && n < 300) begin
      clr_start = (n == 100);
      s();
      n++;
    end
    clr_start = 1'b0;
    chk("busy_len", 64'(n), 64'(CELLS));
    s();
    req0(1, 0, 8'h7F, 8'h00); s();
    req0(1, 0, 8'hFF, 8'h00); s();
    req0(0, 0, 8'h00, 8'h00); s(); s();
    // reset aborts a sweep part way
    req0(1, 1, 8'h40, 8'h3C); s();
    req0(1, 1, 8'h05, 8'h55); s();
    req0(0, 0, 8'h00, 8'h00);
    clr_start = 1'b1; s();
    clr_start = 1'b0;
    req0(1, 0, 8'h05, 8'h00);
    repeat (20) s();
    rst_n = 1'b0;
    #1 chk("rst_abort", 64'({busy, we, m0_ack, m1_ack, m0_rv}), 64'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s();
    req0(1, 0, 8'h40, 8'h00); s();
    req0(0, 0, 8'h00, 8'h00); s(); s();
    // random traffic with occasional clears
    p0 = 1'b0; p1 = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin
        p0 = 1'b1;
        req0(1, 1'($urandom_range(1, 0)), 8'($urandom_range(15, 0)), 8'($urandom));
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        p1 = 1'b1;
        req1(1, 1'($urandom_range(1, 0)), 8'($urandom_range(15, 0)), 8'($urandom));
      end
      clr_start = ($urandom_range(299, 0) == 0);
      step(g0, g1);
      if (g0) begin p0 = 1'b0; m0_req = 1'b0; end
      if (g1) begin p1 = 1'b0; m1_req = 1'b0; end
    end
    clr_start = 1'b0;
    req0(0, 0, 8'h00, 8'h00);
    req1(0, 0, 8'h00, 8'h00);
    repeat (3) s();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
